nor_bus_sequencer: RTL and testbench
====================================

# nor_bus_sequencer

Sequences asynchronous cycles on the parallel NOR flash bus (CE#/OE#/WE#, 26-bit word address, 16-bit DQ) from a single pipelined Wishbone-style request port. It sits between the internal Wishbone NOR target and the FPGA pads. It enforces address setup, strobe width and hold times as cycle counts of the 240 MHz system clock. After program/erase command writes it can optionally wait for RY/BY# to return ready, with a timeout.

## Interface
- `TAS`, 2: address/CE#-to-strobe setup cycles, ≥1
- `TPW_RD`, 24: OE# low width in cycles (100 ns), ≥1
- `TPW_WR`, 10: WE# low width in cycles, ≥1
- `TH`, 2: hold cycles after strobe release, CE# still low, ≥1
- `TBUSY`, 24: cycles ignored after WE# release before RY/BY# is sampled
- `TIMEOUT`, 12_000_000: RY wait limit in cycles (50 ms); 24-bit counter
- `clk_i` in 1: system clock (240 MHz, from PLL)
- `reset_i` in 1: synchronous, active-high reset
- `wb_cyc_i`, `wb_stb_i`, `wb_we_i` in 1 each: request qualifiers
- `wb_adr_i` in 26: word address
- `wb_dat_i` in 16: write data
- `wait_ry_i` in 1: for writes, hold the ack until RY/BY# is ready
- `wb_dat_o` out 16: read data, valid with `wb_ack_o`
- `wb_ack_o` out 1: one-cycle completion pulse
- `wb_err_o` out 1: one-cycle RY-timeout completion pulse, never asserted together with ack
- `wb_stall_o` out 1: high whenever state ≠ IDLE
- `nor_addr_o` out 26; `nor_data_o` out 16; `nor_data_oe` out 1
- `nor_data_i` in 16; `nor_ry_i` in 1 (asynchronous, 1 = ready)
- `nor_ce_o`, `nor_oe_o`, `nor_we_o` out 1 each: active-low strobes
- `nor_ry_o` out 1: synchronized RY/BY# for status

## Operation
- All pad outputs are registered. No combinational path from `wb_*` inputs to `nor_*` outputs.
- `nor_ry_i` passes through a 2-flop synchronizer. Reset value is 2'b11. `nor_ry_o` is the second flop.
- States: IDLE, SETUP, STROBE, HOLD, BUSY, DONE. One down-counter, 24 bits, is shared by all states.
- **IDLE**
  - CE#/OE#/WE# = 1, `nor_data_oe` = 0.
  - If `wb_cyc_i & wb_stb_i`: latch adr, dat, we and `wait_ry_i`. Go to SETUP with cnt = TAS−1.
- **SETUP**
  - CE# = 0. Address is driven. `nor_data_oe` = we.
  - At cnt = 0: go to STROBE with cnt = (we ? TPW_WR : TPW_RD) − 1.
- **STROBE**
  - Read: OE# = 0. Write: WE# = 0.
  - At cnt = 0, a read captures `nor_data_i` into `wb_dat_o`. Go to HOLD with cnt = TH−1.
- **HOLD**
  - Strobes are high. CE# = 0. Address, data and OE are unchanged.
  - At cnt = 0: if (we & wait_ry) go to BUSY with cnt = TBUSY−1, else go to DONE.
- **BUSY**
  - CE# = 1, `nor_data_oe` = 0.
  - During the first TBUSY cycles, RY is ignored.
  - Afterwards: if `nor_ry_o` = 1, go to DONE (ack). If TIMEOUT cycles elapse first, go to DONE (err).
- **DONE**
  - CE# = 1. Pulse `wb_ack_o` or `wb_err_o` for one cycle. Go to IDLE.
- `wb_cyc_i` dropping mid-transaction: the NOR cycle still completes (a program cannot be aborted). The ack/err pulse is suppressed.
- Reset in any state: on the next edge all outputs take their reset values and the state is IDLE.
- Reset values:
  - `nor_ce_o` = `nor_oe_o` = `nor_we_o` = 1
  - `nor_data_oe` = 0; `nor_addr_o` = 0; `nor_data_o` = 0
  - `wb_dat_o` = 0; `wb_ack_o` = `wb_err_o` = `wb_stall_o` = 0
  - `nor_ry_o` = 1

## Timing
- Acceptance occurs at edge 0.
- Read ack is high in cycle TAS+TPW_RD+TH+1 after acceptance. With defaults that is cycle 29.
- Write ack without RY wait is high in cycle TAS+TPW_WR+TH+1 (cycle 15).
- `wb_stall_o` is high from the cycle after acceptance through the DONE cycle. The next acceptance is possible in the cycle after DONE.
- CE# high time between back-to-back transactions is at least 2 cycles (DONE + IDLE).
- Address and data are stable from SETUP through the end of HOLD. OE# and WE# are never low simultaneously.
- Data is sampled on the last STROBE edge, at least TPW_RD cycles after OE# falls.
- Timeout is measured from the end of TBUSY. Err asserts exactly TBUSY+TIMEOUT+1 cycles after entering BUSY.

## Test plan
- **Read.** Reset, then read adr 0x2A_BCDE with the model driving DQ = 0xA55A.
  - CE# falls at cycle 1 and OE# low for 24 cycles.
  - Ack at cycle 29 with `wb_dat_o` = 0xA55A.
  - `nor_addr_o` = 0x2ABCDE throughout.
- **Write, no wait.** Write 0x1234 to 0x555 with `wait_ry_i` = 0.
  - WE# low for 10 cycles.
  - `nor_data_oe` = 1 and DQ = 0x1234 from SETUP through HOLD.
  - Ack at cycle 15.
- **Write, RY wait.** Write with `wait_ry_i` = 1; the model holds RY low for 500 cycles after WE# rises.
  - Ack arrives 500+2..3 cycles after WE# rises (includes synchronizer delay).
  - No err.
- **Timeout.** Use TIMEOUT = 100 and hold RY low permanently.
  - `wb_err_o` pulses once at BUSY entry + 125.
  - Ack stays 0 and the state returns to IDLE.
- **Back-to-back and aborts.** Issue back-to-back reads with stb held high.
  - Stall is respected and CE# is high for at least 2 cycles between reads.
  - Dropping cyc mid-strobe: the cycle still completes and no ack is produced.
- **Reset mid-operation.** Assert reset during STROBE of a write.
  - Next cycle: WE#/CE# = 1, `nor_data_oe` = 0, stall = 0.

Source files
------------

// File: rtl/nor_bus_sequencer_if.sv
// -----------------------------------------------------------------------------
// nor_bus_sequencer_if
// Groups the Wishbone-style request port and the NOR flash pad signals of
// nor_bus_sequencer.
//   Wishbone side : wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i[25:0], wb_dat_i[15:0],
//                   wait_ry_i  -> sequencer
//                   wb_dat_o[15:0], wb_ack_o, wb_err_o, wb_stall_o <- sequencer
//   NOR pad side  : nor_addr_o[25:0], nor_data_o[15:0], nor_data_oe,
//                   nor_ce_o, nor_oe_o, nor_we_o (active low), nor_ry_o
//                   <- sequencer
//                   nor_data_i[15:0], nor_ry_i -> sequencer
// Modport slave is the sequencer's view, master is the environment's view.
// -----------------------------------------------------------------------------
interface nor_bus_sequencer_if;
   logic        wb_cyc_i;
   logic        wb_stb_i;
   logic        wb_we_i;
   logic [25:0] wb_adr_i;
   logic [15:0] wb_dat_i;
   logic        wait_ry_i;
   logic [15:0] wb_dat_o;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic        wb_stall_o;
   logic [25:0] nor_addr_o;
   logic [15:0] nor_data_o;
   logic        nor_data_oe;
   logic [15:0] nor_data_i;
   logic        nor_ry_i;
   logic        nor_ce_o;
   logic        nor_oe_o;
   logic        nor_we_o;
   logic        nor_ry_o;

   modport slave (
      input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wait_ry_i,
      input  nor_data_i, nor_ry_i,
      output wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o,
      output nor_addr_o, nor_data_o, nor_data_oe,
      output nor_ce_o, nor_oe_o, nor_we_o, nor_ry_o
   );

   modport master (
      output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wait_ry_i,
      output nor_data_i, nor_ry_i,
      input  wb_dat_o, wb_ack_o, wb_err_o, wb_stall_o,
      input  nor_addr_o, nor_data_o, nor_data_oe,
      input  nor_ce_o, nor_oe_o, nor_we_o, nor_ry_o
   );
endinterface

// File: rtl/nor_bus_sequencer.sv
// -----------------------------------------------------------------------------
// nor_bus_sequencer
// Turns single Wishbone-style requests into asynchronous NOR flash bus cycles
// with setup / strobe / hold timing expressed in system clock cycles, and
// optionally waits for RY/BY# after a write (with timeout).
// Ports:
//   clk_i   : system clock
//   reset_i : synchronous, active-high reset
//   bus     : nor_bus_sequencer_if.slave (request port + NOR pads)
// All pad outputs come straight from flops; the strobe/enable flops are loaded
// from the decode of the next state so each pad reflects the state it is in.
// -----------------------------------------------------------------------------
module nor_bus_sequencer #(
   parameter int TAS     = 2,
   parameter int TPW_RD  = 24,
   parameter int TPW_WR  = 10,
   parameter int TH      = 2,
   parameter int TBUSY   = 24,
   parameter int TIMEOUT = 12_000_000
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   nor_bus_sequencer_if.slave   bus
);

   localparam logic [23:0] C_TAS     = 24'(TAS - 1);
   localparam logic [23:0] C_TPW_RD  = 24'(TPW_RD - 1);
   localparam logic [23:0] C_TPW_WR  = 24'(TPW_WR - 1);
   localparam logic [23:0] C_TH      = 24'(TH - 1);
   localparam logic [23:0] C_TBUSY   = 24'(TBUSY - 1);
   localparam logic [23:0] C_TIMEOUT = 24'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_BUSY, S_DONE
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [23:0] r_cnt, w_cnt_nxt;
   // In BUSY: 0 = blanking window (RY ignored), 1 = polling RY against timeout
   logic        r_ry_phase, w_ry_phase_nxt;
   logic        r_we, r_wait_ry;
   // Sticky: requester dropped cyc, so the completion pulse must not be sent
   logic        r_abort, w_abort_nxt;
   logic [1:0]  r_ry_sync;

   logic        w_accept, w_capture, w_timeout, w_we_eff, w_active;
   logic        w_ack_nxt, w_err_nxt;

   logic [15:0] r_wb_dat;
   logic        r_ack, r_err, r_stall;
   logic [25:0] r_addr;
   logic [15:0] r_data;
   logic        r_data_oe, r_ce_n, r_oe_n, r_we_n;

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_ry_phase_nxt = r_ry_phase;
      w_accept       = 1'b0;
      w_capture      = 1'b0;
      w_timeout      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.wb_cyc_i && bus.wb_stb_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_SETUP;
               w_cnt_nxt   = C_TAS;
            end
         end
         S_SETUP: begin
            if (r_cnt == '0) begin
               w_state_nxt = S_STROBE;
               w_cnt_nxt   = r_we ? C_TPW_WR : C_TPW_RD;
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         S_STROBE: begin
            if (r_cnt == '0) begin
               w_capture   = ~r_we;
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = C_TH;
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         S_HOLD: begin
            if (r_cnt == '0) begin
               if (r_we && r_wait_ry) begin
                  w_state_nxt    = S_BUSY;
                  w_cnt_nxt      = C_TBUSY;
                  w_ry_phase_nxt = 1'b0;
               end else begin
                  w_state_nxt = S_DONE;
               end
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         S_BUSY: begin
            if (!r_ry_phase) begin
               if (r_cnt == '0) begin
                  w_ry_phase_nxt = 1'b1;
                  w_cnt_nxt      = C_TIMEOUT;
               end else begin
                  w_cnt_nxt = r_cnt - 24'd1;
               end
            end else if (r_ry_sync[1]) begin
               // Ready wins over a timeout expiring in the same cycle
               w_state_nxt = S_DONE;
            end else if (r_cnt == '0) begin
               w_state_nxt = S_DONE;
               w_timeout   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt - 24'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_abort_nxt = (r_state == S_IDLE) ? 1'b0 : (r_abort | ~bus.wb_cyc_i);

      // The cycle being accepted has not latched its direction yet
      w_we_eff  = w_accept ? bus.wb_we_i : r_we;
      w_active  = (w_state_nxt == S_SETUP) || (w_state_nxt == S_STROBE) ||
                  (w_state_nxt == S_HOLD);
      w_ack_nxt = (w_state_nxt == S_DONE) && !w_timeout && !w_abort_nxt;
      w_err_nxt = (w_state_nxt == S_DONE) &&  w_timeout && !w_abort_nxt;
   end

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_ry_phase <= 1'b0;
         r_we       <= 1'b0;
         r_wait_ry  <= 1'b0;
         r_abort    <= 1'b0;
         r_ry_sync  <= 2'b11;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_ry_phase <= w_ry_phase_nxt;
         r_abort    <= w_abort_nxt;
         r_ry_sync  <= {r_ry_sync[0], bus.nor_ry_i};
         if (w_accept) begin
            r_we      <= bus.wb_we_i;
            r_wait_ry <= bus.wait_ry_i;
         end
      end
   end

   // ---------------------------------------------------------------- output registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_wb_dat  <= '0;
         r_ack     <= 1'b0;
         r_err     <= 1'b0;
         r_stall   <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
         r_data_oe <= 1'b0;
         r_ce_n    <= 1'b1;
         r_oe_n    <= 1'b1;
         r_we_n    <= 1'b1;
      end else begin
         if (w_accept) begin
            r_addr <= bus.wb_adr_i;
            r_data <= bus.wb_dat_i;
         end
         if (w_capture) begin
            r_wb_dat <= bus.nor_data_i;
         end
         r_ack     <= w_ack_nxt;
         r_err     <= w_err_nxt;
         r_stall   <= (w_state_nxt != S_IDLE);
         r_ce_n    <= ~w_active;
         r_data_oe <= w_active & w_we_eff;
         r_oe_n    <= ~((w_state_nxt == S_STROBE) & ~w_we_eff);
         r_we_n    <= ~((w_state_nxt == S_STROBE) &  w_we_eff);
      end
   end

   assign bus.wb_dat_o    = r_wb_dat;
   assign bus.wb_ack_o    = r_ack;
   assign bus.wb_err_o    = r_err;
   assign bus.wb_stall_o  = r_stall;
   assign bus.nor_addr_o  = r_addr;
   assign bus.nor_data_o  = r_data;
   assign bus.nor_data_oe = r_data_oe;
   assign bus.nor_ce_o    = r_ce_n;
   assign bus.nor_oe_o    = r_oe_n;
   assign bus.nor_we_o    = r_we_n;
   assign bus.nor_ry_o    = r_ry_sync[1];

endmodule

// File: tb/tb_nor_bus_sequencer.sv
// -----------------------------------------------------------------------------
// tb_nor_bus_sequencer
// Directed bench for nor_bus_sequencer. u_dut uses default timing; u_dut_to
// uses TIMEOUT = 100 for the RY timeout scenario. Cycle k is the clock period
// following edge k-1, where edge 0 is the acceptance edge; outputs are sampled
// on the falling edge inside each cycle.
// -----------------------------------------------------------------------------
module tb_nor_bus_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] dq_model = 16'h0;

   nor_bus_sequencer_if bus ();
   nor_bus_sequencer_if bus2 ();

   nor_bus_sequencer u_dut (.clk_i(clk), .reset_i(rst), .bus(bus));
   nor_bus_sequencer #(.TIMEOUT(100)) u_dut_to (.clk_i(clk), .reset_i(rst), .bus(bus2));

   always #5 clk = ~clk;

   // Flash model: drives DQ only while OE# is low
   always @(negedge clk) begin
      bus.nor_data_i  = (bus.nor_oe_o == 1'b0) ? dq_model : 16'h0000;
      bus2.nor_data_i = 16'h0000;
   end

   task automatic start_req(input logic we, input logic [25:0] adr,
                            input logic [15:0] dat, input logic wry);
      @(negedge clk);
      bus.wb_cyc_i  = 1'b1;
      bus.wb_stb_i  = 1'b1;
      bus.wb_we_i   = we;
      bus.wb_adr_i  = adr;
      bus.wb_dat_i  = dat;
      bus.wait_ry_i = wry;
      @(negedge clk);
      bus.wb_stb_i  = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      bus.wb_cyc_i = 1'b0;
      bus.wb_stb_i = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({bus.nor_ce_o, bus.nor_oe_o, bus.nor_we_o} !== 3'b111) begin errors++;
         $display("FAIL reset_strobes: got %b expected 111", {bus.nor_ce_o, bus.nor_oe_o, bus.nor_we_o}); end
      checks++; if (bus.nor_data_oe !== 1'b0 || bus.nor_addr_o !== 26'h0 || bus.nor_data_o !== 16'h0) begin errors++;
         $display("FAIL reset_pads: oe=%b addr=%h data=%h expected 0/0/0", bus.nor_data_oe, bus.nor_addr_o, bus.nor_data_o); end
      checks++; if (bus.wb_dat_o !== 16'h0 || bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0 || bus.wb_stall_o !== 1'b0) begin errors++;
         $display("FAIL reset_wb: dat=%h ack=%b err=%b stall=%b expected all 0", bus.wb_dat_o, bus.wb_ack_o, bus.wb_err_o, bus.wb_stall_o); end
      checks++; if (bus.nor_ry_o !== 1'b1) begin errors++;
         $display("FAIL reset_ry: got %b expected 1", bus.nor_ry_o); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_read();
      int ce_first = -1, oe_first = -1, oe_low = 0, we_low = 0;
      int ack_cnt = 0, ack_cyc = -1, adr_bad = 0, stall_hi = 0;
      logic [15:0] dat_ack = 16'h0;
      dq_model = 16'hA55A;
      start_req(1'b0, 26'h2ABCDE, 16'h0, 1'b0);
      for (int k = 1; k <= 32; k++) begin
         if (bus.nor_ce_o == 1'b0 && ce_first < 0) ce_first = k;
         if (bus.nor_oe_o == 1'b0) begin oe_low++; if (oe_first < 0) oe_first = k; end
         if (bus.nor_we_o == 1'b0) we_low++;
         if (bus.wb_ack_o) begin ack_cnt++; ack_cyc = k; dat_ack = bus.wb_dat_o; end
         if (k <= 28 && bus.nor_addr_o !== 26'h2ABCDE) adr_bad++;
         if (bus.wb_stall_o) stall_hi++;
         @(negedge clk);
      end
      checks++; if (ce_first !== 1) begin errors++; $display("FAIL read_ce_fall: cycle %0d expected 1", ce_first); end
      checks++; if (oe_low !== 24 || oe_first !== 3) begin errors++;
         $display("FAIL read_oe_width: %0d cycles from %0d expected 24 from 3", oe_low, oe_first); end
      checks++; if (we_low !== 0) begin errors++; $display("FAIL read_we_low: %0d cycles expected 0", we_low); end
      checks++; if (ack_cnt !== 1 || ack_cyc !== 29) begin errors++;
         $display("FAIL read_ack: %0d pulses at cycle %0d expected 1 at 29", ack_cnt, ack_cyc); end
      checks++; if (dat_ack !== 16'hA55A) begin errors++; $display("FAIL read_data: got %h expected a55a", dat_ack); end
      checks++; if (adr_bad !== 0) begin errors++; $display("FAIL read_addr: %0d bad cycles expected 0", adr_bad); end
      checks++; if (stall_hi !== 29) begin errors++; $display("FAIL read_stall: %0d cycles expected 29", stall_hi); end
      idle_cycles(3);
   endtask

   task automatic test_write_nowait();
      int we_low = 0, oe_low = 0, bad = 0, ack_cyc = -1, ack_cnt = 0;
      logic oe_after = 1'b1;
      start_req(1'b1, 26'h555, 16'h1234, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         if (bus.nor_we_o == 1'b0) we_low++;
         if (bus.nor_oe_o == 1'b0) oe_low++;
         if (k <= 14 && (bus.nor_data_oe !== 1'b1 || bus.nor_data_o !== 16'h1234 || bus.nor_addr_o !== 26'h555)) bad++;
         if (k == 15) oe_after = bus.nor_data_oe;
         if (bus.wb_ack_o) begin ack_cnt++; ack_cyc = k; end
         @(negedge clk);
      end
      checks++; if (we_low !== 10 || oe_low !== 0) begin errors++;
         $display("FAIL write_strobes: we_low=%0d oe_low=%0d expected 10/0", we_low, oe_low); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL write_bus_drive: %0d bad cycles expected 0", bad); end
      checks++; if (oe_after !== 1'b0) begin errors++; $display("FAIL write_oe_release: got %b expected 0", oe_after); end
      checks++; if (ack_cnt !== 1 || ack_cyc !== 15) begin errors++;
         $display("FAIL write_ack: %0d pulses at cycle %0d expected 1 at 15", ack_cnt, ack_cyc); end
      idle_cycles(3);
   endtask

   task automatic test_write_rywait();
      logic seen_low = 1'b0;
      int rise = -1, ack_n = -1, err_cnt = 0, ack_cnt = 0;
      start_req(1'b1, 26'h2AA, 16'h00A0, 1'b1);
      for (int k = 1; k <= 600; k++) begin
         if (bus.nor_we_o == 1'b0) begin seen_low = 1'b1; bus.nor_ry_i = 1'b0; end
         else if (seen_low && rise < 0) rise = k;
         if (rise >= 0 && k - rise == 500) bus.nor_ry_i = 1'b1;
         if (bus.wb_ack_o) begin ack_cnt++; if (ack_n < 0) ack_n = k - rise; end
         if (bus.wb_err_o) err_cnt++;
         @(negedge clk);
      end
      bus.nor_ry_i = 1'b1;
      checks++; if (ack_cnt !== 1 || ack_n < 502 || ack_n > 504) begin errors++;
         $display("FAIL rywait_ack: %0d pulses, %0d cycles after WE# rise expected 1 in 502..504", ack_cnt, ack_n); end
      checks++; if (err_cnt !== 0) begin errors++; $display("FAIL rywait_err: %0d pulses expected 0", err_cnt); end
      idle_cycles(3);
   endtask

   task automatic test_timeout();
      int err_cnt = 0, err_cyc = -1, ack_cnt = 0;
      logic stall_end = 1'b1, ce_busy = 1'b0, oe_busy = 1'b1;
      bus2.nor_ry_i = 1'b0;
      @(negedge clk);
      bus2.wb_cyc_i = 1'b1; bus2.wb_stb_i = 1'b1; bus2.wb_we_i = 1'b1;
      bus2.wb_adr_i = 26'h123; bus2.wb_dat_i = 16'h0030; bus2.wait_ry_i = 1'b1;
      @(negedge clk);
      bus2.wb_stb_i = 1'b0;
      for (int k = 1; k <= 145; k++) begin
         if (bus2.wb_err_o) begin err_cnt++; err_cyc = k; end
         if (bus2.wb_ack_o) ack_cnt++;
         if (k == 15) begin ce_busy = bus2.nor_ce_o; oe_busy = bus2.nor_data_oe; end
         if (k == 140) stall_end = bus2.wb_stall_o;
         @(negedge clk);
      end
      bus2.wb_cyc_i = 1'b0;
      bus2.nor_ry_i = 1'b1;
      checks++; if (ce_busy !== 1'b1 || oe_busy !== 1'b0) begin errors++;
         $display("FAIL timeout_busy_pads: ce=%b data_oe=%b expected 1/0", ce_busy, oe_busy); end
      checks++; if (err_cnt !== 1 || err_cyc !== 139) begin errors++;
         $display("FAIL timeout_err: %0d pulses at cycle %0d expected 1 at 139", err_cnt, err_cyc); end
      checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL timeout_ack: %0d pulses expected 0", ack_cnt); end
      checks++; if (stall_end !== 1'b0) begin errors++; $display("FAIL timeout_idle: stall=%b expected 0", stall_end); end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int ack_cnt = 0, ack2 = -1, hi_run = 0, min_run = 1000;
      logic prev_ce = 1'b1;
      logic [15:0] dat2 = 16'h0;
      dq_model = 16'h0F0F;
      @(negedge clk);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = 26'h0100; bus.wait_ry_i = 1'b0;
      @(negedge clk);
      for (int k = 1; k <= 62; k++) begin
         if (k == 40) bus.wb_stb_i = 1'b0;
         if (bus.nor_ce_o == 1'b1) hi_run++;
         else begin
            if (prev_ce == 1'b1 && k > 1 && hi_run < min_run) min_run = hi_run;
            hi_run = 0;
         end
         prev_ce = bus.nor_ce_o;
         if (bus.wb_ack_o) begin ack_cnt++; ack2 = k; dat2 = bus.wb_dat_o; end
         @(negedge clk);
      end
      checks++; if (ack_cnt !== 2 || ack2 !== 59) begin errors++;
         $display("FAIL b2b_acks: %0d pulses, last at %0d expected 2, last at 59", ack_cnt, ack2); end
      checks++; if (min_run !== 2) begin errors++; $display("FAIL b2b_ce_gap: %0d cycles expected 2", min_run); end
      checks++; if (dat2 !== 16'h0F0F) begin errors++; $display("FAIL b2b_data: got %h expected 0f0f", dat2); end
      idle_cycles(3);
   endtask

   task automatic test_abort();
      int oe_low = 0, ce_low = 0, ack_cnt = 0;
      logic stall_end = 1'b1;
      dq_model = 16'h5AA5;
      start_req(1'b0, 26'h0777, 16'h0, 1'b0);
      for (int k = 1; k <= 32; k++) begin
         if (k == 10) bus.wb_cyc_i = 1'b0;
         if (bus.nor_oe_o == 1'b0) oe_low++;
         if (bus.nor_ce_o == 1'b0) ce_low++;
         if (bus.wb_ack_o || bus.wb_err_o) ack_cnt++;
         if (k == 30) stall_end = bus.wb_stall_o;
         @(negedge clk);
      end
      checks++; if (oe_low !== 24 || ce_low !== 28) begin errors++;
         $display("FAIL abort_completes: oe_low=%0d ce_low=%0d expected 24/28", oe_low, ce_low); end
      checks++; if (ack_cnt !== 0) begin errors++; $display("FAIL abort_no_ack: %0d pulses expected 0", ack_cnt); end
      checks++; if (stall_end !== 1'b0) begin errors++; $display("FAIL abort_idle: stall=%b expected 0", stall_end); end
      idle_cycles(3);
   endtask

   task automatic test_reset_midop();
      logic we_mid = 1'b1;
      start_req(1'b1, 26'h0AAA, 16'h0055, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         if (k == 5) we_mid = bus.nor_we_o;
         if (k == 6) begin
            checks++; if (bus.nor_we_o !== 1'b1 || bus.nor_ce_o !== 1'b1) begin errors++;
               $display("FAIL midrst_strobes: we=%b ce=%b expected 1/1", bus.nor_we_o, bus.nor_ce_o); end
            checks++; if (bus.nor_data_oe !== 1'b0 || bus.wb_stall_o !== 1'b0) begin errors++;
               $display("FAIL midrst_state: data_oe=%b stall=%b expected 0/0", bus.nor_data_oe, bus.wb_stall_o); end
         end
         if (k == 5) rst = 1'b1;
         @(negedge clk);
      end
      rst = 1'b0;
      checks++; if (we_mid !== 1'b0) begin errors++; $display("FAIL midrst_in_strobe: we=%b expected 0", we_mid); end
      idle_cycles(3);
   endtask

   initial begin
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wait_ry_i = 1'b0; bus.nor_ry_i = 1'b1;
      bus2.wb_cyc_i = 1'b0; bus2.wb_stb_i = 1'b0; bus2.wb_we_i = 1'b0;
      bus2.wb_adr_i = '0; bus2.wb_dat_i = '0; bus2.wait_ry_i = 1'b0; bus2.nor_ry_i = 1'b1;
      test_reset();
      test_read();
      test_write_nowait();
      test_write_rywait();
      test_timeout();
      test_back_to_back();
      test_abort();
      test_reset_midop();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
